// File: rtl/flow_tick_gen_if.sv
// Key inputs and step/state outputs of the flowing-light tick generator.
// master drives the raw keys; slave is the generator itself.
interface flow_tick_gen_if;
    logic       key_speed;
    logic       key_dir;
    logic       key_pause;
    logic       step;
    logic       dir;
    logic [1:0] speed_lvl;
    logic       paused;

    modport master (
        output key_speed, key_dir, key_pause,
        input  step, dir, speed_lvl, paused
    );

    modport slave (
        input  key_speed, key_dir, key_pause,
        output step, dir, speed_lvl, paused
    );
endinterface

// File: rtl/flow_tick_gen.sv
// Conditions three raw push buttons and produces a rate-selectable one-cycle
// step strobe plus direction / pause state for the LED shifter.
module flow_tick_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned BASE_PERIOD     = 25_000_000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    flow_tick_gen_if.slave   bus
);
    localparam int unsigned   DW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    // key bit order: [0] speed, [1] dir, [2] pause
    logic [2:0]    key_raw;
    logic [2:0]    s1_q, s2_q;
    logic [2:0]    deb_q, deb_d;
    logic [2:0]    deb_dly_q;
    logic [2:0]    press_ev;
    logic [DW-1:0] dcnt_q [3];
    logic [DW-1:0] dcnt_d [3];

    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   period;
    logic          step_q, step_d;
    logic          dir_q, dir_d;
    logic [1:0]    speed_lvl_q, speed_lvl_d;
    logic          paused_q, paused_d;

    assign key_raw  = {bus.key_pause, bus.key_dir, bus.key_speed};
    assign press_ev = deb_q & ~deb_dly_q;

    // Any cycle where the synchronised key matches the accepted level
    // restarts qualification, so short glitches never accumulate.
    always_comb begin
        deb_d = deb_q;
        for (int k = 0; k < 3; k++) begin
            dcnt_d[k] = '0;
            if (s2_q[k] != deb_q[k]) begin
                if (dcnt_q[k] == DEB_LAST) begin
                    deb_d[k] = s2_q[k];
                end else begin
                    dcnt_d[k] = dcnt_q[k] + DW'(1);
                end
            end
        end
    end

    always_comb begin
        period      = 32'(BASE_PERIOD) >> speed_lvl_q;
        cnt_d       = cnt_q;
        step_d      = 1'b0;
        speed_lvl_d = speed_lvl_q + {1'b0, press_ev[0]};
        dir_d       = dir_q ^ press_ev[1];
        paused_d    = paused_q ^ press_ev[2];
        // A pause event on the terminal cycle still lets that step out;
        // the halt takes effect from the following cycle.
        if (press_ev[0]) begin
            cnt_d = '0;
        end else if (paused_q) begin
            cnt_d = cnt_q;
        end else if (cnt_q == period - 32'd1) begin
            step_d = 1'b1;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q        <= '0;
            s2_q        <= '0;
            deb_q       <= '0;
            deb_dly_q   <= '0;
            for (int k = 0; k < 3; k++) dcnt_q[k] <= '0;
            cnt_q       <= '0;
            step_q      <= 1'b0;
            dir_q       <= 1'b0;
            speed_lvl_q <= 2'd0;
            paused_q    <= 1'b0;
        end else begin
            s1_q        <= key_raw;
            s2_q        <= s1_q;
            deb_q       <= deb_d;
            deb_dly_q   <= deb_q;
            for (int k = 0; k < 3; k++) dcnt_q[k] <= dcnt_d[k];
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            dir_q       <= dir_d;
            speed_lvl_q <= speed_lvl_d;
            paused_q    <= paused_d;
        end
    end

    assign bus.step      = step_q;
    assign bus.dir       = dir_q;
    assign bus.speed_lvl = speed_lvl_q;
    assign bus.paused    = paused_q;
endmodule

// File: tb/tb_flow_tick_gen.sv
// Directed bench for flow_tick_gen: per-cycle comparison against a reference
// model plus hand-computed latency, cadence and state expectations.
module tb_flow_tick_gen;
    localparam int DEB  = 4;
    localparam int BASE = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic cmp_en = 1'b0;

    flow_tick_gen_if bus ();

    flow_tick_gen #(.DEBOUNCE_CYCLES(DEB), .BASE_PERIOD(BASE)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: keys seen through a two-cycle delay line, a level is
    // accepted after DEB consecutive differing cycles, steps every P cycles.
    logic [2:0]  m_pipe1, m_pipe2, m_acc, m_acc_prev;
    int          m_run [3];
    int unsigned m_cnt;
    logic [1:0]  m_lvl;
    logic        m_dir, m_paused, m_step;

    always @(posedge clk) begin
        logic [2:0]  raw, ev;
        int unsigned per;
        raw = {bus.key_pause, bus.key_dir, bus.key_speed};
        if (rst) begin
            m_pipe1 = '0; m_pipe2 = '0; m_acc = '0; m_acc_prev = '0;
            for (int k = 0; k < 3; k++) m_run[k] = 0;
            m_cnt = 0; m_lvl = 0; m_dir = 0; m_paused = 0; m_step = 0;
        end else begin
            ev  = m_acc & ~m_acc_prev;
            per = BASE >> m_lvl;
            m_step = 1'b0;
            if (ev[0]) m_cnt = 0;
            else if (!m_paused) begin
                if (m_cnt == per - 1) begin m_step = 1'b1; m_cnt = 0; end
                else m_cnt = m_cnt + 1;
            end
            m_acc_prev = m_acc;
            for (int k = 0; k < 3; k++) begin
                if (m_pipe2[k] != m_acc[k]) begin
                    m_run[k] = m_run[k] + 1;
                    if (m_run[k] == DEB) begin m_acc[k] = m_pipe2[k]; m_run[k] = 0; end
                end else m_run[k] = 0;
            end
            m_pipe2 = m_pipe1;
            m_pipe1 = raw;
            m_lvl    = m_lvl + {1'b0, ev[0]};
            m_dir    = m_dir ^ ev[1];
            m_paused = m_paused ^ ev[2];
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if ({bus.step, bus.dir, bus.speed_lvl, bus.paused} !== {m_step, m_dir, m_lvl, m_paused}) begin
                errors++;
                $display("FAIL model_cmp t=%0t got step/dir/lvl/paused=%b/%b/%0d/%b required %b/%b/%0d/%b",
                         $time, bus.step, bus.dir, bus.speed_lvl, bus.paused, m_step, m_dir, m_lvl, m_paused);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            0: bus.key_speed = v;
            1: bus.key_dir   = v;
            default: bus.key_pause = v;
        endcase
    endtask

    // From a negedge: count edges until step is seen high (bounded).
    task automatic wait_step(output int n);
        n = 0;
        while (bus.step !== 1'b1 && n < 200) begin
            @(posedge clk); @(negedge clk); n++;
        end
    endtask

    task automatic check_gap(input string name, input int exp);
        int n;
        wait_step(n);
        n = 0;
        do begin
            @(posedge clk); @(negedge clk); n++;
        end while (bus.step !== 1'b1 && n < 200);
        check(name, n, exp);
    endtask

    task automatic press(input int k);
        set_key(k, 1'b1);
        repeat (8) @(negedge clk);
        set_key(k, 1'b0);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int n;
        bus.key_speed = 1'b0; bus.key_dir = 1'b0; bus.key_pause = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        check("reset_outputs", int'({bus.step, bus.dir, bus.speed_lvl, bus.paused}), 0);
        rst = 1'b0;
        n = 0;
        do begin @(posedge clk); @(negedge clk); n++; end while (bus.step !== 1'b1 && n < 200);
        check("first_step_latency", n, 16);
        check_gap("period_lvl0", 16);

        for (int i = 0; i < 10; i++) begin
            bus.key_speed = (i % 2 == 0);
            repeat (2) @(negedge clk);
        end
        bus.key_speed = 1'b1;
        repeat (10) @(negedge clk);
        bus.key_speed = 1'b0;
        repeat (10) @(negedge clk);
        check("bounce_one_event", bus.speed_lvl, 1);
        check_gap("period_lvl1", 8);

        press(0); check("lvl_2", bus.speed_lvl, 2); check_gap("period_lvl2", 4);
        press(0); check("lvl_3", bus.speed_lvl, 3); check_gap("period_lvl3", 2);
        press(0); check("lvl_wrap", bus.speed_lvl, 0); check_gap("period_wrap", 16);

        bus.key_speed = 1'b1;
        repeat (3) @(negedge clk);
        bus.key_speed = 1'b0;
        repeat (12) @(negedge clk);
        check("short_press_lvl", bus.speed_lvl, 0);
        check_gap("short_press_period", 16);

        // Pause event lands on the cycle with cnt=5 of the next period.
        wait_step(n);
        repeat (15) @(posedge clk);
        @(negedge clk);
        bus.key_pause = 1'b1;
        repeat (8) @(negedge clk);
        bus.key_pause = 1'b0;
        check("paused_set", bus.paused, 1);
        n = 0;
        repeat (40) begin @(negedge clk); if (bus.step === 1'b1) n++; end
        check("no_step_while_paused", n, 0);
        bus.key_pause = 1'b1;
        n = 0;
        while (bus.paused !== 1'b0 && n < 50) begin @(posedge clk); @(negedge clk); n++; end
        check("resume_latency", n, 7);
        bus.key_pause = 1'b0;
        n = 0;
        do begin @(posedge clk); @(negedge clk); n++; end while (bus.step !== 1'b1 && n < 200);
        check("resume_first_step", n, 10);

        // Pause event on the terminal-count cycle.
        wait_step(n);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.key_pause = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("pause_on_terminal", int'({bus.step, bus.paused}), 3);
        bus.key_pause = 1'b0;
        repeat (10) @(negedge clk);
        press(2);
        check("unpaused", bus.paused, 0);

        press(1);
        press(0);
        press(0);
        press(2);
        check("pre_reset_state", int'({bus.dir, bus.speed_lvl, bus.paused}), 'b1101);
        bus.key_dir = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_mid_run", int'({bus.step, bus.dir, bus.speed_lvl, bus.paused}), 0);
        n = 0;
        do begin @(posedge clk); @(negedge clk); n++; end while (bus.dir !== 1'b1 && n < 50);
        check("held_key_after_reset", n, 7);
        repeat (10) @(negedge clk);
        check("dir_toggled_once", bus.dir, 1);
        bus.key_dir = 1'b0;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
